// File: rtl/branch_unit.sv
// Branch resolution and program counter: holds the condition-code register, evaluates
// one of 16 branch conditions and steers the PC, killing the shadow slot of a taken branch.
module branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cc_in,
  input  logic        cc_we,
  input  logic        br_valid,
  input  logic [3:0]  br_cond,
  input  logic        br_abs,
  input  logic [15:0] br_offset,
  input  logic        stall,
  output logic [15:0] pc_out,
  output logic [3:0]  cc_q,
  output logic        resolved,
  output logic        taken,
  output logic        flush
);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StShadow = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [3:0]  cc_reg_q, cc_reg_d;
  logic        resolved_q, resolved_d;
  logic        taken_q, taken_d;
  logic        flush_q, flush_d;

  logic [3:0]  cc_eff;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_true;
  logic [15:0] target;
  logic [15:0] pc_inc;

  // Flags being written this cycle are visible to a branch in the same cycle.
  assign cc_eff = cc_we ? cc_in : cc_reg_q;
  assign {flag_n, flag_z, flag_c, flag_v} = cc_eff;

  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = flag_z;
      4'h3: cond_true = ~flag_z;
      4'h4: cond_true = flag_n;
      4'h5: cond_true = ~flag_n;
      4'h6: cond_true = flag_c;
      4'h7: cond_true = ~flag_c;
      4'h8: cond_true = flag_v;
      4'h9: cond_true = ~flag_v;
      4'hA: cond_true = ~flag_z & (flag_n == flag_v);
      4'hB: cond_true = (flag_n == flag_v);
      4'hC: cond_true = (flag_n != flag_v);
      4'hD: cond_true = flag_z | (flag_n != flag_v);
      4'hE: cond_true = flag_c & ~flag_z;
      4'hF: cond_true = ~flag_c | flag_z;
      default: cond_true = 1'b0;
    endcase
  end

  assign target = br_abs ? br_offset : (pc_q + br_offset);
  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cc_reg_d   = cc_we ? cc_in : cc_reg_q;
    resolved_d = 1'b0;
    taken_d    = 1'b0;
    flush_d    = 1'b0;
    if (!stall) begin
      unique case (state_q)
        StRun: begin
          if (br_valid && cond_true) begin
            pc_d       = target;
            resolved_d = 1'b1;
            taken_d    = 1'b1;
            state_d    = StShadow;
          end else begin
            pc_d       = pc_inc;
            resolved_d = br_valid;
          end
        end
        StShadow: begin
          // Shadow slot is killed; any branch presented here is dropped.
          pc_d    = pc_inc;
          flush_d = 1'b1;
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      cc_reg_q   <= 4'b0000;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cc_reg_q   <= cc_reg_d;
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_out   = pc_q;
  assign cc_q     = cc_reg_q;
  assign resolved = resolved_q;
  assign taken    = taken_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed table-driven bench for branch_unit with RESET_PC = 16'h0100.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cc_in;
  logic        cc_we;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic        br_abs;
  logic [15:0] br_offset;
  logic        stall;
  logic [15:0] pc_out;
  logic [3:0]  cc_q;
  logic        resolved;
  logic        taken;
  logic        flush;

  int checks = 0;
  int errors = 0;

  branch_unit #(.RESET_PC(16'h0100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cc_in     (cc_in),
    .cc_we     (cc_we),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_abs    (br_abs),
    .br_offset (br_offset),
    .stall     (stall),
    .pc_out    (pc_out),
    .cc_q      (cc_q),
    .resolved  (resolved),
    .taken     (taken),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        cc_we;
    logic [3:0]  cc_in;
    logic        br_valid;
    logic [3:0]  cond;
    logic        abs;
    logic [15:0] off;
    logic [15:0] exp_pc;
    logic [3:0]  exp_cc;
    logic        exp_res;
    logic        exp_tkn;
    logic        exp_fl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic we, input logic [3:0] ci, input logic bv,
                     input logic [3:0] cd, input logic ab, input logic [15:0] of,
                     input logic [15:0] pc, input logic [3:0] cc, input logic rs,
                     input logic tk, input logic fl);
    vec_t v;
    v.stall = st; v.cc_we = we; v.cc_in = ci; v.br_valid = bv; v.cond = cd; v.abs = ab;
    v.off = of; v.exp_pc = pc; v.exp_cc = cc; v.exp_res = rs; v.exp_tkn = tk; v.exp_fl = fl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic [3:0] cc,
                         input logic rs, input logic tk, input logic fl);
    chk({tag, " pc"}, pc_out, pc);
    chk({tag, " cc"}, {12'd0, cc_q}, {12'd0, cc});
    chk({tag, " resolved"}, {15'd0, resolved}, {15'd0, rs});
    chk({tag, " taken"}, {15'd0, taken}, {15'd0, tk});
    chk({tag, " flush"}, {15'd0, flush}, {15'd0, fl});
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; cc_we = v.cc_we; cc_in = v.cc_in; br_valid = v.br_valid;
    br_cond = v.cond; br_abs = v.abs; br_offset = v.off;
  endtask

  initial begin
    // st we  cc_in  bv cond  abs off       pc        cc     rs tk fl
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0101, 4'h0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0102, 4'h0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0103, 4'h0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 4'h0, 1, 16'h001F, 16'h001F, 4'h0, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0020, 4'h0, 0, 0, 1);
    // bypass EQ with negative offset
    add(0, 1, 4'h4, 1, 4'h2, 0, 16'hFFF0, 16'h0010, 4'h4, 1, 1, 0);
    // branch in shadow slot is killed
    add(0, 0, 4'h0, 1, 4'h0, 0, 16'h0100, 16'h0011, 4'h4, 0, 0, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0012, 4'h4, 0, 0, 0);
    // signed conditions with N=1 V=0
    add(0, 1, 4'h8, 0, 4'h0, 0, 16'h0000, 16'h0013, 4'h8, 0, 0, 0);
    add(0, 0, 4'h0, 1, 4'hC, 0, 16'h0010, 16'h0023, 4'h8, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0024, 4'h8, 0, 0, 1);
    add(0, 0, 4'h0, 1, 4'hB, 0, 16'h0010, 16'h0025, 4'h8, 1, 0, 0);
    add(0, 0, 4'h0, 1, 4'hA, 0, 16'h0010, 16'h0026, 4'h8, 1, 0, 0);
    add(0, 1, 4'h9, 1, 4'hB, 0, 16'h0010, 16'h0036, 4'h9, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0037, 4'h9, 0, 0, 1);
    // wrap and absolute
    add(0, 0, 4'h0, 1, 4'h0, 1, 16'hFFFE, 16'hFFFE, 4'h9, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'hFFFF, 4'h9, 0, 0, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h0000, 4'h9, 0, 0, 0);
    add(0, 0, 4'h0, 1, 4'h0, 1, 16'h1234, 16'h1234, 4'h9, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h1235, 4'h9, 0, 0, 1);
    // NV, HI, LS, NE
    add(0, 0, 4'h0, 1, 4'h1, 0, 16'h0010, 16'h1236, 4'h9, 1, 0, 0);
    add(0, 1, 4'h2, 1, 4'hE, 0, 16'h0002, 16'h1238, 4'h2, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h1239, 4'h2, 0, 0, 1);
    add(0, 0, 4'h0, 1, 4'hF, 0, 16'h0002, 16'h123A, 4'h2, 1, 0, 0);
    add(0, 0, 4'h0, 1, 4'h3, 0, 16'hFFFF, 16'h1239, 4'h2, 1, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h123A, 4'h2, 0, 0, 1);
    // stall holds PC but not the cc register
    add(1, 1, 4'h1, 1, 4'h0, 1, 16'h4000, 16'h123A, 4'h1, 0, 0, 0);
    add(1, 1, 4'h3, 1, 4'h0, 1, 16'h4000, 16'h123A, 4'h3, 0, 0, 0);
    add(1, 0, 4'h0, 1, 4'h0, 1, 16'h4000, 16'h123A, 4'h3, 0, 0, 0);
    add(0, 0, 4'h0, 1, 4'h0, 1, 16'h4000, 16'h4000, 4'h3, 1, 1, 0);
    // stall in shadow delays flush
    add(1, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h4000, 4'h3, 0, 0, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 16'h4001, 4'h3, 0, 0, 1);

    rst_n = 1'b0; stall = 0; cc_we = 0; cc_in = 0; br_valid = 0; br_cond = 0;
    br_abs = 0; br_offset = 0;
    repeat (3) @(negedge clk);
    chk_all("reset", 16'h0100, 4'h0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].exp_pc, vq[i].exp_cc, vq[i].exp_res,
              vq[i].exp_tkn, vq[i].exp_fl);
      @(negedge clk);
    end

    // Reset asserted mid-shadow drops the pending flush.
    cc_we = 0; stall = 0; br_valid = 1; br_cond = 4'h0; br_abs = 1; br_offset = 16'h0500;
    @(posedge clk);
    #1;
    chk_all("pre-reset branch", 16'h0500, 4'h3, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 16'h0100, 4'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; br_valid = 0; br_abs = 0; br_offset = 0;
    @(posedge clk);
    #1;
    chk_all("post-reset run", 16'h0101, 4'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
